mem_req_ctrl: RTL and testbench

- CPU-side initiator for the data-memory port; sits between the MEM pipeline stage and a word-wide data memory.
- Turns load/store ops into word-aligned requests with byte enables and a req/gnt/rvalid handshake.
- Extracts and sign- or zero-extends load data, and stalls the pipeline until each access completes.
- Detects misaligned addresses and responder timeouts.

---
 rtl/mem_req_ctrl_pkg.sv | 40 ++++
 rtl/mem_req_ctrl_if.sv | 21 ++
 rtl/mem_req_ctrl_load_extend.sv | 26 ++
 rtl/mem_req_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_req_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mem_req_ctrl_pkg.sv
// Shared encodings for the data-memory request controller and its load
// extraction helper.
package mem_req_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_BYTE = 4'b0001;

    function automatic logic is_store(op_e op);
        return op inside {OP_SW, OP_SH, OP_SB};
    endfunction

    // Bytes are always aligned; halves need bit 0 clear, words both bits.
    function automatic logic misaligned(op_e op, logic [1:0] lo);
        case (op)
            OP_LW, OP_SW:         return lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return lo[0];
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Word-wide data-memory bus: request/grant plus read-data-valid return.
interface mem_req_ctrl_if #(parameter int AW = 32);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_req_ctrl_load_extend.sv
// Combinational lane select and sign/zero extension of a loaded word.
// Kept standalone so the fetch bypass can share it.
module load_extend
    import mem_req_ctrl_pkg::*;
(
    input  logic [2:0]  op_type,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b      = word[{addr, 3'b000} +: 8];
        h      = word[{addr[1], 4'b0000} +: 16];
        result = word;
        case (op_e'(op_type))
            OP_LB:   result = {{24{b[7]}}, b};
            OP_LBU:  result = {24'h0, b};
            OP_LH:   result = {{16{h[15]}}, h};
            OP_LHU:  result = {16'h0, h};
            default: result = word;
        endcase
    end
endmodule

// File: rtl/mem_req_ctrl.sv
// MEM-stage initiator: turns load/store ops into aligned word requests,
// stalls the pipe until completion and reports alignment/timeout errors.
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op_valid,
    input  logic [2:0]    op_type,
    input  logic [AW-1:0] op_addr,
    input  logic [31:0]   op_wdata,
    input  logic [31:0]   pc8,
    output logic          stall,
    output logic          done,
    output logic [31:0]   rdata,
    output logic          adel,
    output logic          ades,
    output logic          bus_err,
    mem_req_ctrl_if.master mem
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    op_e           op_in, op_q;
    logic [1:0]    lo_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    be_q, be_n;
    logic [31:0]   wdata_q, wdata_n, rdata_q, ext;
    logic          we_q, adel_q, ades_q, berr_q;
    logic          mis, st, tmo, capture;

    assign op_in = op_e'(op_type);
    assign mis   = misaligned(op_in, op_addr[1:0]);
    assign st    = is_store(op_in);

    // Lane placement for stores; loads always fetch the whole word.
    always_comb begin
        be_n    = BE_WORD;
        wdata_n = 32'h0;
        case (op_in)
            OP_SW: wdata_n = op_wdata;
            OP_SH: begin
                be_n    = BE_HALF << {op_addr[1], 1'b0};
                wdata_n = {2{op_wdata[15:0]}};
            end
            OP_SB: begin
                be_n    = BE_BYTE << op_addr[1:0];
                wdata_n = {4{op_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    load_extend u_ext (
        .op_type (op_q),
        .addr    (lo_q),
        .word    (mem.mem_rdata),
        .result  (ext)
    );

    // A zero-latency responder may return data in the grant cycle.
    assign capture = !we_q && mem.mem_rvalid &&
                     ((state_q == REQ && mem.mem_gnt) || state_q == WAIT_R);
    assign tmo = (cnt_q == TMAX) &&
                 ((state_q == REQ && !mem.mem_gnt) || (state_q == WAIT_R && !mem.mem_rvalid));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (op_valid) state_d = mis ? DONE : REQ;
            REQ: begin
                if (mem.mem_gnt)  state_d = (we_q || mem.mem_rvalid) ? DONE : WAIT_R;
                else if (tmo)     state_d = DONE;
            end
            WAIT_R: if (mem.mem_rvalid || tmo) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_LW;
            lo_q    <= 2'b00;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            rdata_q <= 32'h0;
            adel_q  <= 1'b0;
            ades_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (op_valid) begin
                    op_q    <= op_in;
                    lo_q    <= op_addr[1:0];
                    adel_q  <= mis && !st;
                    ades_q  <= mis && st;
                    berr_q  <= 1'b0;
                    rdata_q <= 32'h0;
                    if (!mis) begin
                        addr_q  <= {op_addr[AW-1:2], 2'b00};
                        be_q    <= be_n;
                        wdata_q <= wdata_n;
                        we_q    <= st;
                        cnt_q   <= '0;
                    end
                end
                REQ, WAIT_R: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (capture) rdata_q <= ext;
                    if (tmo)     berr_q  <= 1'b1;
                end
                DONE: begin
                    adel_q <= 1'b0;
                    ades_q <= 1'b0;
                    berr_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign done          = (state_q == DONE);
    assign stall         = op_valid && (state_q != DONE);
    assign rdata         = rdata_q;
    assign adel          = done && adel_q;
    assign ades          = done && ades_q;
    assign bus_err       = done && berr_q;
    assign mem.mem_req   = (state_q == REQ);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && state_q == REQ && mem.mem_gnt && we_q)
            $display("%d@%h: *%h <= %h", $time, pc8 - 32'd8, op_addr, op_wdata);
    end
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed vector bench for mem_req_ctrl with a cycle-scripted responder.
module tb_mem_req_ctrl;
    import mem_req_ctrl_pkg::*;

    localparam int NEVER = 99;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_type;
    logic [31:0] op_addr, op_wdata, pc8;
    logic        stall, done, adel, ades, bus_err;
    logic [31:0] rdata;

    mem_req_ctrl_if #(.AW(32)) mem ();

    mem_req_ctrl #(.TIMEOUT(16), .AW(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op_type  (op_type),
        .op_addr  (op_addr),
        .op_wdata (op_wdata),
        .pc8      (pc8),
        .stall    (stall),
        .done     (done),
        .rdata    (rdata),
        .adel     (adel),
        .ades     (ades),
        .bus_err  (bus_err),
        .mem      (mem.master)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr, wdata, word;
        int          gnt_dly, rv_dly;
        int          done_cyc;
        logic        req;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic        we;
        logic [31:0] rd;
        logic [2:0]  err;   // {adel, ades, bus_err}
    } vec_t;

    function automatic vec_t mk(logic [2:0] op, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] word, int gd, int rvd, int dc, logic req,
                                logic [31:0] maddr, logic [3:0] be, logic [31:0] mwd,
                                logic we, logic [31:0] rd, logic [2:0] err);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.word = word;
        v.gnt_dly = gd; v.rv_dly = rvd; v.done_cyc = dc; v.req = req;
        v.maddr = maddr; v.be = be; v.mwd = mwd; v.we = we; v.rd = rd; v.err = err;
        return v;
    endfunction

    // Cycle 0 is the op_valid cycle; gnt_dly counts REQ cycles before the
    // grant, rv_dly counts cycles from grant to rvalid.
    task automatic run_op(input vec_t v, input string tag);
        int          cyc, req_cnt, gnt_cyc, done_at, stall_n;
        logic        req_seen, hold_bad;
        logic [31:0] a, w, rd_got;
        logic [3:0]  b;
        logic        we_got;
        logic [2:0]  err_got;
        cyc = 0; req_cnt = 0; gnt_cyc = -1; done_at = -1; stall_n = 0;
        req_seen = 1'b0; hold_bad = 1'b0;
        a = '0; w = '0; b = '0; we_got = 1'b0; rd_got = '0; err_got = '0;
        @(posedge clk); #1;
        op_type = v.op; op_addr = v.addr; op_wdata = v.wdata;
        pc8 = 32'h0000_1008 + v.addr; op_valid = 1'b1;
        while (done_at < 0 && cyc < 40) begin
            mem.mem_gnt    = mem.mem_req && (req_cnt == v.gnt_dly);
            if (mem.mem_gnt) gnt_cyc = cyc;
            mem.mem_rvalid = (gnt_cyc >= 0) && (cyc == gnt_cyc + v.rv_dly) && (v.op < 3'd5);
            mem.mem_rdata  = mem.mem_rvalid ? v.word : 32'h5555_AAAA;
            @(negedge clk);
            if (stall) stall_n++;
            if (mem.mem_req) begin
                if (!req_seen) begin
                    a = mem.mem_addr; b = mem.mem_be; w = mem.mem_wdata; we_got = mem.mem_we;
                end else if (mem.mem_addr !== a || mem.mem_be !== b ||
                             mem.mem_wdata !== w || mem.mem_we !== we_got) begin
                    hold_bad = 1'b1;
                end
                req_seen = 1'b1;
                req_cnt++;
            end
            if (done) begin
                done_at = cyc;
                rd_got  = rdata;
                err_got = {adel, ades, bus_err};
                op_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        op_valid = 1'b0;
        mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;
        @(negedge clk);
        chk({tag, ".done_cyc"}, done_at, v.done_cyc);
        chk({tag, ".stall_n"}, stall_n, v.done_cyc);
        chk({tag, ".done_pulse"}, {done, mem.mem_req}, 32'h0);
        chk({tag, ".req_seen"}, req_seen, v.req);
        if (v.req) begin
            chk({tag, ".addr"}, a, v.maddr);
            chk({tag, ".be"}, b, v.be);
            chk({tag, ".wdata"}, w, v.mwd);
            chk({tag, ".we"}, we_got, v.we);
            chk({tag, ".hold"}, hold_bad, 1'b0);
        end
        chk({tag, ".rdata"}, rd_got, v.rd);
        chk({tag, ".err"}, err_got, v.err);
    endtask

    vec_t vt[15];

    initial begin
        logic stray_req;
        vt[0]  = mk(OP_SW,  32'h10,  32'hDEADBEEF, 32'h0,         0, 0,      2,  1, 32'h10,  4'hF, 32'hDEADBEEF, 1, 32'h0,         3'b000);
        vt[1]  = mk(OP_SB,  32'h13,  32'h000000A5, 32'h0,         0, 0,      2,  1, 32'h10,  4'h8, 32'hA5A5A5A5, 1, 32'h0,         3'b000);
        vt[2]  = mk(OP_SH,  32'h1A,  32'h1234BEEF, 32'h0,         2, 0,      4,  1, 32'h18,  4'hC, 32'hBEEFBEEF, 1, 32'h0,         3'b000);
        vt[3]  = mk(OP_LB,  32'h22,  32'h0,        32'h12803456,  0, 2,      4,  1, 32'h20,  4'hF, 32'h0,        0, 32'hFFFFFF80,  3'b000);
        vt[4]  = mk(OP_LBU, 32'h22,  32'h0,        32'h12803456,  0, 2,      4,  1, 32'h20,  4'hF, 32'h0,        0, 32'h00000080,  3'b000);
        vt[5]  = mk(OP_LH,  32'h06,  32'h0,        32'h80017FFF,  1, 0,      3,  1, 32'h04,  4'hF, 32'h0,        0, 32'hFFFF8001,  3'b000);
        vt[6]  = mk(OP_LHU, 32'h04,  32'h0,        32'h8001F00D,  0, 1,      3,  1, 32'h04,  4'hF, 32'h0,        0, 32'h0000F00D,  3'b000);
        vt[7]  = mk(OP_LW,  32'h100, 32'h0,        32'hCAFEF00D,  0, 0,      2,  1, 32'h100, 4'hF, 32'h0,        0, 32'hCAFEF00D,  3'b000);
        vt[8]  = mk(OP_LB,  32'h03,  32'h0,        32'h7F000000,  0, 1,      3,  1, 32'h00,  4'hF, 32'h0,        0, 32'h0000007F,  3'b000);
        vt[9]  = mk(OP_LH,  32'h05,  32'h0,        32'h0,         0, 0,      1,  0, 32'h0,   4'h0, 32'h0,        0, 32'h0,         3'b100);
        vt[10] = mk(OP_SW,  32'h06,  32'h11223344, 32'h0,         0, 0,      1,  0, 32'h0,   4'h0, 32'h0,        0, 32'h0,         3'b010);
        vt[11] = mk(OP_SH,  32'h03,  32'h11223344, 32'h0,         0, 0,      1,  0, 32'h0,   4'h0, 32'h0,        0, 32'h0,         3'b010);
        vt[12] = mk(OP_LW,  32'h40,  32'h0,        32'h12345678,  NEVER, 0,  17, 1, 32'h40,  4'hF, 32'h0,        0, 32'h0,         3'b001);
        vt[13] = mk(OP_LW,  32'h44,  32'h0,        32'h12345678,  0, NEVER,  17, 1, 32'h44,  4'hF, 32'h0,        0, 32'h0,         3'b001);
        vt[14] = mk(OP_SB,  32'h01,  32'h0000005A, 32'h0,         1, 0,      3,  1, 32'h00,  4'h2, 32'h5A5A5A5A, 1, 32'h0,         3'b000);

        reset = 1'b1; op_valid = 1'b0; op_type = 3'd0; op_addr = '0; op_wdata = '0; pc8 = '0;
        mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
        #1;
        chk("reset.state", 32'(dut.state_q), 32'(IDLE));
        chk("reset.ctl", {done, stall, adel, ades, bus_err, mem.mem_req, mem.mem_we}, 32'h0);
        chk("reset.addr", mem.mem_addr, 32'h0);
        chk("reset.be_wdata", {mem.mem_be, mem.mem_wdata[27:0]}, 32'h0);
        chk("reset.rdata", rdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 15; i++) run_op(vt[i], $sformatf("v%0d", i));

        // Asynchronous reset while waiting for read data.
        @(posedge clk); #1;
        op_type = OP_LW; op_addr = 32'h80; op_wdata = '0; pc8 = 32'h1088; op_valid = 1'b1;
        @(posedge clk); #1;
        mem.mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem.mem_gnt = 1'b0;
        chk("arst.pre_state", 32'(dut.state_q), 32'(WAIT_R));
        #2 reset = 1'b1;
        #1;
        chk("arst.state", 32'(dut.state_q), 32'(IDLE));
        chk("arst.done_req", {done, mem.mem_req}, 32'h0);
        chk("arst.addr", mem.mem_addr, 32'h0);
        op_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
        stray_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem.mem_req || done) stray_req = 1'b1;
        end
        chk("arst.no_reissue", stray_req, 1'b0);
        run_op(vt[7], "arst.lw");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
